// File: rtl/dwt_analysis_stage.sv
// dwt_analysis_stage: one-level db2 analysis bank, Lo_D/Hi_D filters, decimate by 2.
// Optional DWT_ANALYSIS_ROUND_EN: rescale Q8 sums with round-half-up.
module dwt_analysis_stage #(
  parameter int w_in  = 9,
  parameter int y_out = 25,
  parameter int c_in  = 9
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sync,
  input  logic                    in_valid,
  input  logic signed [w_in-1:0]  x_in,
  output logic signed [y_out-1:0] a_out,
  output logic signed [y_out-1:0] d_out,
  output logic                    out_valid
);

  localparam int pw = w_in + c_in;
  localparam int sw = pw + 2;

  localparam logic signed [c_in-1:0] lo_c [4] = '{
    c_in'(-34), c_in'(57), c_in'(214), c_in'(123)
  };
  localparam logic signed [c_in-1:0] hi_c [4] = '{
    c_in'(-123), c_in'(214), c_in'(-57), c_in'(-34)
  };

  logic signed [w_in-1:0] tap [4];
  logic                   phase;
  logic                   v1;
  logic                   v2;
  logic signed [pw-1:0]   p_lo [4];
  logic signed [pw-1:0]   p_hi [4];
  logic signed [sw-1:0]   s_lo;
  logic signed [sw-1:0]   s_hi;
  logic signed [sw-1:0]   r_lo;
  logic signed [sw-1:0]   r_hi;

  // v1 marks an accepted sample taken while phase=1 (odd n)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) tap[i] <= '0;
      phase <= 1'b0;
      v1    <= 1'b0;
    end else if (sync) begin
      tap[0] <= in_valid ? x_in : '0;
      for (int i = 1; i < 4; i++) tap[i] <= '0;
      phase <= in_valid;
      v1    <= 1'b0;
    end else if (in_valid) begin
      tap[0] <= x_in;
      for (int i = 1; i < 4; i++) tap[i] <= tap[i-1];
      phase <= ~phase;
      v1    <= phase;
    end else begin
      v1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin
        p_lo[i] <= '0;
        p_hi[i] <= '0;
      end
      v2 <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        p_lo[i] <= pw'(tap[i]) * pw'(lo_c[i]);
        p_hi[i] <= pw'(tap[i]) * pw'(hi_c[i]);
      end
      v2 <= v1;
    end
  end

  always_comb begin
    s_lo = '0;
    s_hi = '0;
    for (int i = 0; i < 4; i++) begin
      s_lo = s_lo + sw'(p_lo[i]);
      s_hi = s_hi + sw'(p_hi[i]);
    end
  end

`ifdef DWT_ANALYSIS_ROUND_EN
  assign r_lo = (s_lo + sw'(128)) >>> 8;
  assign r_hi = (s_hi + sw'(128)) >>> 8;
`else
  assign r_lo = s_lo;
  assign r_hi = s_hi;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_out     <= '0;
      d_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        a_out <= y_out'(r_lo);
        d_out <= y_out'(r_hi);
      end
    end
  end

endmodule

// File: tb/tb_dwt_analysis_stage.sv
// tb_dwt_analysis_stage: vector table, directed corner sequences and
// random stimulus checked against a sample-history reference model.
module tb_dwt_analysis_stage;

  logic               clk = 1'b0;
  logic               rstn = 1'b1;
  logic               sync = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [8:0]  x_in = '0;
  logic signed [24:0] a_out;
  logic signed [24:0] d_out;
  logic               out_valid;

  always #5 clk = ~clk;

  dwt_analysis_stage dut (
    .clk(clk),
    .rstn(rstn),
    .sync(sync),
    .in_valid(in_valid),
    .x_in(x_in),
    .a_out(a_out),
    .d_out(d_out),
    .out_valid(out_valid)
  );

  typedef struct {
    int due;
    int a;
    int d;
  } exp_t;

  typedef struct {
    int x;
    bit v;
    bit s;
    bit ev;
    int ea;
    int ed;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc_no = 0;
  int cnt = 0;
  int held_a = 0;
  int held_d = 0;
  int lo [4] = '{-34, 57, 214, 123};
  int hi [4] = '{-123, 214, -57, -34};
  int hist [$];
  exp_t q [$];
  int pa [$];
  int pd [$];
  int pc [$];
  vec_t tbl [9];

  function automatic int sc(input int y);
`ifdef DWT_ANALYSIS_ROUND_EN
    return (y + 128) >>> 8;
`else
    return y;
`endif
  endfunction

  task automatic chk(input string nm, input bit ev,
                     input int ea, input int ed);
    int ga;
    int gd;
    ga = a_out;
    gd = d_out;
    checks++;
    if (out_valid !== ev || ga != ea || gd != ed) begin
      errors++;
      $display("FAIL %s cyc=%0d got v=%0b a=%0d d=%0d want v=%0b a=%0d d=%0d",
               nm, cyc_no, out_valid, ga, gd, ev, ea, ed);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic model_in(input int x, input bit v, input bit s);
    int ya;
    int yd;
    int tmp;
    if (s) begin
      hist.delete();
      cnt = 0;
    end
    if (v) begin
      hist.push_front(x);
      if (hist.size() > 4) tmp = hist.pop_back();
      if (cnt % 2 == 1) begin
        ya = 0;
        yd = 0;
        for (int k = 0; k < hist.size(); k++) begin
          ya += lo[k] * hist[k];
          yd += hi[k] * hist[k];
        end
        q.push_back('{cyc_no + 3, sc(ya), sc(yd)});
      end
      cnt++;
    end
  endtask

  task automatic check_out();
    bit ev;
    int ea;
    int ed;
    exp_t e;
    ev = 1'b0;
    ea = held_a;
    ed = held_d;
    if (q.size() != 0 && q[0].due == cyc_no) begin
      e = q.pop_front();
      ev = 1'b1;
      ea = e.a;
      ed = e.d;
      held_a = e.a;
      held_d = e.d;
    end
    chk("model", ev, ea, ed);
  endtask

  task automatic cyc(input int x, input bit v, input bit s);
    x_in = x[8:0];
    in_valid = v;
    sync = s;
    model_in(x, v, s);
    @(negedge clk);
    cyc_no++;
    check_out();
    if (out_valid === 1'b1) begin
      pa.push_back(int'(a_out));
      pd.push_back(int'(d_out));
      pc.push_back(cyc_no);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    in_valid = 1'b0;
    sync = 1'b0;
    #1;
    q.delete();
    hist.delete();
    cnt = 0;
    held_a = 0;
    held_d = 0;
    chk("reset_now", 1'b0, 0, 0);
    @(negedge clk);
    cyc_no++;
    chk("reset_hold", 1'b0, 0, 0);
    rstn = 1'b1;
  endtask

  task automatic clr_pulses();
    pa.delete();
    pd.delete();
    pc.delete();
  endtask

  initial begin
    int wa [5];
    int wd [5];

    tbl[0] = '{1, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[1] = '{0, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[2] = '{0, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[3] = '{0, 1'b1, 1'b0, 1'b1, sc(57), sc(214)};
    tbl[4] = '{0, 1'b1, 1'b0, 1'b0, sc(57), sc(214)};
    tbl[5] = '{0, 1'b1, 1'b0, 1'b1, sc(123), sc(-34)};
    tbl[6] = '{0, 1'b0, 1'b0, 1'b0, sc(123), sc(-34)};
    tbl[7] = '{0, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[8] = '{0, 1'b0, 1'b0, 1'b0, 0, 0};

    #2;
    do_reset();

    // impulse from the table
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].x, tbl[i].v, tbl[i].s);
      chk($sformatf("impulse_%0d", i), tbl[i].ev, tbl[i].ea, tbl[i].ed);
    end

    // DC
    for (int i = 0; i < 12; i++) cyc(100, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b0);
    chk("dc", 1'b0, sc(36000), 0);

    // reset with an output in flight
    cyc(100, 1'b1, 1'b0);
    cyc(100, 1'b1, 1'b0);
    do_reset();
    cyc(0, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b0);
    chk("rst_no_ghost", 1'b0, 0, 0);
    cyc(3, 1'b1, 1'b0);
    cyc(4, 1'b1, 1'b0);
    cyc(0, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b0);
    chk("rst_first", 1'b1, sc(35), sc(150));

    // negative full scale
    for (int i = 0; i < 10; i++) cyc(-256, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b0);
    chk("negfs", 1'b0, sc(-92160), 0);

    // gapped impulse
    do_reset();
    clr_pulses();
    for (int i = 0; i < 6; i++) begin
      cyc((i == 0) ? 1 : 0, 1'b1, 1'b0);
      cyc(0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 1'b0, 1'b0);
    chk_int("gap_pulses", pc.size(), 3);
    if (pc.size() == 3) begin
      chk_int("gap_space1", pc[1] - pc[0], 4);
      chk_int("gap_space2", pc[2] - pc[1], 4);
      chk_int("gap_a0", pa[0], sc(57));
      chk_int("gap_d0", pd[0], sc(214));
      chk_int("gap_a1", pa[1], sc(123));
      chk_int("gap_d1", pd[1], sc(-34));
      chk_int("gap_a2", pa[2], 0);
      chk_int("gap_d2", pd[2], 0);
    end

    // sync mid-stream
    do_reset();
    clr_pulses();
    for (int i = 0; i < 5; i++) cyc(100, 1'b1, 1'b0);
    cyc(1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cyc(0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(0, 1'b0, 1'b0);
    wa = '{sc(2300), sc(36000), sc(57), sc(123), 0};
    wd = '{sc(9100), 0, sc(214), sc(-34), 0};
    chk_int("sync_pulses", pc.size(), 5);
    if (pc.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk_int($sformatf("sync_a%0d", i), pa[i], wa[i]);
        chk_int($sformatf("sync_d%0d", i), pd[i], wd[i]);
      end
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cyc($urandom_range(0, 511) - 256,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 31) == 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 1'b0, 1'b0);
    chk_int("drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
